// File: rtl/bzmusic_seq_dp.sv
// Buzzer music score datapath: score memory, note pointer, beat counter, tone generator.
// Optional rest support (tune 0 silences the buzzer) is enabled with `define BZMUSIC_REST_EN.
module bzmusic_seq_dp #(
    parameter int ADDR_W      = 5,
    parameter int BEAT_CYCLES = 12500000,
    parameter int TUNE_SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              addr_en,
    input  logic              addr_rstn,
    input  logic              tune_pwm_en,
    input  logic              tune_pwm_rstn,
    input  logic              beat_cnt_en,
    input  logic              beat_cnt_rstn,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [15:0]       cfg_wdata,
    output logic              music_finish,
    output logic              beat_finish,
    output logic              buzzer,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam int          DEPTH     = 1 << ADDR_W;
    localparam int          HW        = 12 + TUNE_SHIFT;
    localparam logic [23:0] BEAT_LAST = 24'(BEAT_CYCLES - 1);

    logic [15:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_ptr;
    logic              r_end;
    logic [11:0]       r_note_tune;
    logic [3:0]        r_beats_left;
    logic [23:0]       r_beat_cnt;
    logic [HW-1:0]     r_tune_cnt;
    logic              r_buzzer;

    logic [15:0]       w_cur;
    logic              w_fetch;
    logic              w_beat_wrap;
    logic [11:0]       w_tune;
    logic [HW-1:0]     w_half;
    logic [HW-1:0]     w_half_last;

    assign w_cur       = r_mem[r_ptr];
    assign w_fetch     = addr_rstn & addr_en;
    assign w_beat_wrap = beat_cnt_rstn & beat_cnt_en & (r_beat_cnt == BEAT_LAST);

`ifdef BZMUSIC_REST_EN
    logic w_rest;
    assign w_rest = (r_note_tune == 12'd0);
    assign w_tune = r_note_tune;
`else
    // Without rest support a zero tune plays the shortest period.
    assign w_tune = (r_note_tune == 12'd0) ? 12'd1 : r_note_tune;
`endif

    assign w_half      = HW'(w_tune) << TUNE_SHIFT;
    assign w_half_last = w_half - HW'(1);

    // Fetch reads before the write lands, so same-address fetch sees old data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (cfg_we) begin
            r_mem[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
            r_end <= 1'b0;
        end else if (!addr_rstn) begin
            r_ptr <= '0;
            r_end <= 1'b0;
        end else if (addr_en) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            if (r_ptr == '1) begin
                r_end <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_note_tune <= '0;
        end else if (w_fetch) begin
            r_note_tune <= w_cur[11:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beats_left <= '0;
        end else if (w_fetch) begin
            r_beats_left <= w_cur[15:12];
        end else if (w_beat_wrap) begin
            r_beats_left <= r_beats_left - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat_cnt <= '0;
        end else if (!beat_cnt_rstn) begin
            r_beat_cnt <= '0;
        end else if (beat_cnt_en) begin
            if (r_beat_cnt == BEAT_LAST) begin
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tune_cnt <= '0;
            r_buzzer   <= 1'b0;
        end else if (!tune_pwm_rstn) begin
            r_tune_cnt <= '0;
            r_buzzer   <= 1'b0;
        end else if (tune_pwm_en) begin
`ifdef BZMUSIC_REST_EN
            if (w_rest) begin
                r_tune_cnt <= '0;
                r_buzzer   <= 1'b0;
            end else
`endif
            if (r_tune_cnt == w_half_last) begin
                r_tune_cnt <= '0;
                r_buzzer   <= ~r_buzzer;
            end else begin
                r_tune_cnt <= r_tune_cnt + HW'(1);
            end
        end
    end

    assign music_finish = r_end | (w_cur[15:12] == 4'd0);
    assign beat_finish  = beat_cnt_en & (r_beat_cnt == BEAT_LAST)
                        & (r_beats_left == 4'd1);
    assign buzzer       = r_buzzer;
    assign cur_addr     = r_ptr;

endmodule

// File: tb/tb_bzmusic_seq_dp.sv
// Scoreboard bench for bzmusic_seq_dp: stimulus pushes model predictions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_bzmusic_seq_dp;

    localparam int AW = 2;
    localparam int BC = 4;
    localparam int TS = 0;
`ifdef BZMUSIC_REST_EN
    localparam bit REST = 1'b1;
`else
    localparam bit REST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          addr_en = 1'b0;
    logic          addr_rstn = 1'b0;
    logic          tune_pwm_en = 1'b0;
    logic          tune_pwm_rstn = 1'b0;
    logic          beat_cnt_en = 1'b0;
    logic          beat_cnt_rstn = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [15:0]   cfg_wdata = '0;
    logic          music_finish;
    logic          beat_finish;
    logic          buzzer;
    logic [AW-1:0] cur_addr;

    bzmusic_seq_dp #(
        .ADDR_W(AW),
        .BEAT_CYCLES(BC),
        .TUNE_SHIFT(TS)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .addr_en(addr_en),
        .addr_rstn(addr_rstn),
        .tune_pwm_en(tune_pwm_en),
        .tune_pwm_rstn(tune_pwm_rstn),
        .beat_cnt_en(beat_cnt_en),
        .beat_cnt_rstn(beat_cnt_rstn),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .music_finish(music_finish),
        .beat_finish(beat_finish),
        .buzzer(buzzer),
        .cur_addr(cur_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          mf;
        logic          bf;
        logic          bz;
        logic [AW-1:0] ca;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   last_bf;

    // Reference model: the note is tracked as enabled cycles elapsed since
    // it was fetched, and the tone as enabled cycles since its last clear.
    int m_mem[1<<AW];
    int m_ptr;
    bit m_end;
    int m_tune;
    int m_beats;
    int m_el;
    int m_t;

    function automatic void m_reset();
        foreach (m_mem[i]) m_mem[i] = 0;
        m_ptr = 0; m_end = 0; m_tune = 0;
        m_beats = 0; m_el = 0; m_t = 0;
    endfunction

    function automatic int m_half();
        int tv;
        tv = m_tune;
        if (tv == 0) tv = REST ? 0 : 1;
        return tv << TS;
    endfunction

    function automatic bit m_mf();
        return m_end || ((m_mem[m_ptr] >> 12) == 0);
    endfunction

    function automatic bit m_buz();
        int h;
        h = m_half();
        if (h == 0) return 1'b0;
        return ((m_t / h) % 2) == 1;
    endfunction

    function automatic void m_step();
        int fetched;
        int el_n;
        fetched = m_mem[m_ptr];
        if (!tune_pwm_rstn) m_t = 0;
        else if (tune_pwm_en) begin
            if (REST && m_tune == 0) m_t = 0;
            else m_t++;
        end
        if (!beat_cnt_rstn) el_n = m_el - (m_el % BC);
        else if (beat_cnt_en) el_n = m_el + 1;
        else el_n = m_el;
        if (addr_en && addr_rstn) begin
            m_beats = fetched >> 12;
            m_tune  = fetched & 'hfff;
            m_el    = el_n % BC;
        end else begin
            m_el = el_n;
        end
        if (!addr_rstn) begin
            m_ptr = 0; m_end = 0;
        end else if (addr_en) begin
            if (m_ptr == (1 << AW) - 1) m_end = 1;
            m_ptr = (m_ptr + 1) % (1 << AW);
        end
        if (cfg_we) m_mem[int'(cfg_addr)] = int'(cfg_wdata);
    endfunction

    task automatic cyc();
        exp_t e;
        if (!rstn) m_reset();
        e.mf = m_mf();
        e.bf = beat_cnt_en && ((m_el % BC) == BC - 1)
            && (((m_beats - m_el / BC) & 15) == 1);
        e.bz = m_buz();
        e.ca = AW'(m_ptr);
        q.push_back(e);
        last_bf = e.bf;
        if (rstn) m_step();
        @(posedge clk);
        #1;
    endtask

    function automatic void chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("music_finish", int'(music_finish), int'(e.mf));
            chk("beat_finish", int'(beat_finish), int'(e.bf));
            chk("buzzer", int'(buzzer), int'(e.bz));
            chk("cur_addr", int'(cur_addr), int'(e.ca));
        end
    end

    task automatic wr(input int a, input int d);
        cfg_we = 1; cfg_addr = AW'(a); cfg_wdata = 16'(d);
        cyc();
        cfg_we = 0;
    endtask

    task automatic ptr_clr();
        addr_rstn = 0;
        cyc();
        addr_rstn = 1;
    endtask

    task automatic fetch();
        addr_en = 1; tune_pwm_rstn = 0; beat_cnt_rstn = 0;
        cyc();
        addr_en = 0; tune_pwm_rstn = 1; beat_cnt_rstn = 1;
    endtask

    function automatic int rnd_entry();
        return ($urandom_range(0, 3) << 12) | $urandom_range(0, 5);
    endfunction

    task automatic play(input int maxc, input bit gaps, input bit wrr);
        int n;
        bit on;
        n = 0;
        last_bf = 0;
        while (!last_bf && n < maxc) begin
            on = !gaps || ($urandom_range(0, 3) != 0);
            tune_pwm_en = on; beat_cnt_en = on;
            if (wrr && $urandom_range(0, 9) == 0) begin
                cfg_we = 1; cfg_addr = AW'($urandom);
                cfg_wdata = 16'(rnd_entry());
            end
            cyc();
            cfg_we = 0;
            n++;
        end
        tune_pwm_en = 0; beat_cnt_en = 0;
        checks++;
        if (!last_bf) begin
            errors++;
            $display("FAIL play_timeout: no beat_finish within %0d cycles", maxc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        @(posedge clk);
        #1;
        // reset with all inputs low
        cyc(); cyc();
        rstn = 1;
        cyc();
        addr_rstn = 1; tune_pwm_rstn = 1; beat_cnt_rstn = 1;
        cyc();

        // single note: 2 beats, tune 3
        wr(0, 'h2003); wr(1, 'h0000);
        fetch();
        play(40, 0, 0);
        cyc(); cyc();

        // wrap through all entries
        for (int i = 0; i < 4; i++) wr(i, 'h1000 | (i + 1));
        ptr_clr();
        for (int i = 0; i < 4; i++) fetch();
        cyc();
        ptr_clr();
        cyc();

        // same-cycle write and fetch at entry 0
        wr(0, 'h1002);
        ptr_clr();
        cfg_we = 1; cfg_addr = 0; cfg_wdata = 16'h1005;
        fetch();
        cfg_we = 0;
        play(40, 0, 0);
        cyc();

        // rest / zero tune
        wr(0, 'h1000);
        ptr_clr();
        fetch();
        play(40, 0, 0);
        cyc();

        // clear counters mid-note
        wr(0, 'h2003); wr(1, 'h0000);
        ptr_clr();
        fetch();
        tune_pwm_en = 1; beat_cnt_en = 1;
        cyc(); cyc();
        tune_pwm_rstn = 0; beat_cnt_rstn = 0;
        cyc();
        tune_pwm_rstn = 1; beat_cnt_rstn = 1;
        play(40, 0, 0);
        cyc();

        // async reset mid-note
        wr(0, 'h3001);
        ptr_clr();
        fetch();
        tune_pwm_en = 1; beat_cnt_en = 1;
        for (int i = 0; i < 5; i++) cyc();
        rstn = 0;
        cyc();
        rstn = 1; tune_pwm_en = 0; beat_cnt_en = 0;
        cyc(); cyc();

        // randomized scores played by a controller-like sequence
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) wr(i, rnd_entry());
            ptr_clr();
            for (int k = 0; k < 6 && !m_mf(); k++) begin
                fetch();
                play(200, 1, 1);
                if ($urandom_range(0, 1) == 1) cyc();
            end
            cyc();
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
